// File: rtl/cache_trace_gen.sv
// cache_trace_gen: programmable address-trace source for the cache simulator.
// Optional TRACE_GEN_REPEAT_EN issues every generated address twice in a row.
module cache_trace_gen #(
    parameter int                ADDR_W    = 31,
    parameter int                LINE_SIZE = 16,
    parameter logic [ADDR_W-1:0] SEED      = 31'h0000_0010
) (
    input  logic              clk_41,
    input  logic              rst_41,
    input  logic              start_41,
    input  logic [1:0]        mode_41,
    input  logic [ADDR_W-1:0] base_41,
    input  logic [15:0]       stride_41,
    input  logic [ADDR_W-1:0] span_41,
    input  logic [ADDR_W-1:0] count_41,
    output logic [ADDR_W-1:0] addr_41,
    output logic              addr_valid_41,
    input  logic              addr_ready_41,
    output logic              busy_41,
    output logic              done_41,
    output logic [ADDR_W-1:0] issued_41
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_SIZE - 1));

    state_t            state;
    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] base_r;
    logic [15:0]       stride_r;
    logic [ADDR_W-1:0] span_r;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] lfsr_r;
    logic [ADDR_W:0]   offset_r;

    logic [ADDR_W-1:0] stride_ext;
    logic [ADDR_W:0]   off_sum;
    logic [ADDR_W:0]   off_next;
    logic [ADDR_W-1:0] lfsr_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] issued_inc;
    logic              xfer;
    logic              last_xfer;
    logic              advance;

`ifdef TRACE_GEN_REPEAT_EN
    logic rep_r;

    // second copy of an address is the one that lets the generator advance
    always_comb begin
        advance = rep_r;
    end
`else
    // every transfer advances the generator
    always_comb begin
        advance = 1'b1;
    end
`endif

    // next-address generation from the latched trace parameters
    always_comb begin
        stride_ext = {{(ADDR_W - 16){1'b0}}, stride_r};
        off_sum    = offset_r + {{(ADDR_W + 1 - 16){1'b0}}, stride_r};
        off_next   = off_sum;
        if (span_r != '0 && off_sum >= {1'b0, span_r}) begin
            off_next = '0;
        end
        lfsr_next = {lfsr_r[ADDR_W-2:0],
                     lfsr_r[ADDR_W-1] ^ lfsr_r[ADDR_W-4]};
        unique case (mode_r)
            2'd1:    addr_next = base_r + off_next[ADDR_W-1:0];
            2'd2:    addr_next = base_r + (lfsr_next & LINE_MASK);
            default: addr_next = addr_41 + stride_ext;
        endcase
    end

    // first address of a trace, taken straight from the start inputs
    always_comb begin
        unique case (mode_41)
            2'd2:    first_addr = base_41 + (SEED & LINE_MASK);
            default: first_addr = base_41;
        endcase
    end

    // handshake bookkeeping
    always_comb begin
        xfer       = addr_valid_41 && addr_ready_41;
        issued_inc = issued_41 + 1'b1;
        last_xfer  = (issued_inc == count_r);
    end

    // trace FSM with registered outputs and generator state
    always_ff @(posedge clk_41) begin
        if (rst_41) begin
            state         <= IDLE;
            addr_41       <= '0;
            addr_valid_41 <= 1'b0;
            busy_41       <= 1'b0;
            done_41       <= 1'b0;
            issued_41     <= '0;
            lfsr_r        <= SEED;
            offset_r      <= '0;
            mode_r        <= '0;
            base_r        <= '0;
            stride_r      <= '0;
            span_r        <= '0;
            count_r       <= '0;
`ifdef TRACE_GEN_REPEAT_EN
            rep_r         <= 1'b0;
`endif
        end else begin
            done_41 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_41) begin
                        mode_r    <= mode_41;
                        base_r    <= base_41;
                        stride_r  <= stride_41;
                        span_r    <= span_41;
                        count_r   <= count_41;
                        issued_41 <= '0;
                        lfsr_r    <= SEED;
                        offset_r  <= '0;
`ifdef TRACE_GEN_REPEAT_EN
                        rep_r     <= 1'b0;
`endif
                        if (count_41 != '0) begin
                            addr_41       <= first_addr;
                            addr_valid_41 <= 1'b1;
                            busy_41       <= 1'b1;
                            state         <= RUN;
                        end else begin
                            done_41 <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        issued_41 <= issued_inc;
`ifdef TRACE_GEN_REPEAT_EN
                        rep_r     <= ~rep_r;
`endif
                        if (last_xfer) begin
                            addr_valid_41 <= 1'b0;
                            busy_41       <= 1'b0;
                            done_41       <= 1'b1;
                            state         <= DONE;
                        end else if (advance) begin
                            addr_41  <= addr_next;
                            lfsr_r   <= lfsr_next;
                            offset_r <= off_next;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
